// File: rtl/buffer_window_ctrl_if.sv
// Handshake and buffer-address bundle between feeder, column buffer, PE read port and buffer_window_ctrl.
// No latency of its own; in_valid/in_ready and out_valid/out_ready carry the backpressure (BUF_WINDOW_CTRL_STATS_EN adds stall counters).
// master = feeder/consumer side, slave = controller side.
interface buffer_window_ctrl_if #(
    parameter int COLUMNS   = 32,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ  = 4
);
    localparam int AW = $clog2(COLUMNS);

    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic                    out_ready;
    logic                    out_valid;
    logic                    buf_wen;
    logic [PAR_WRITE*AW-1:0] buf_waddr;
    logic [PAR_READ*AW-1:0]  buf_raddr;
    logic [AW:0]             count;
    logic                    busy;
    logic                    done;
`ifdef BUF_WINDOW_CTRL_STATS_EN
    logic [15:0]             wr_stall_cnt;
    logic [15:0]             rd_stall_cnt;

    modport master (
        output in_valid, in_last, out_ready,
        input  in_ready, out_valid, buf_wen, buf_waddr, buf_raddr, count, busy, done,
        input  wr_stall_cnt, rd_stall_cnt
    );
    modport slave (
        input  in_valid, in_last, out_ready,
        output in_ready, out_valid, buf_wen, buf_waddr, buf_raddr, count, busy, done,
        output wr_stall_cnt, rd_stall_cnt
    );
`else
    modport master (
        output in_valid, in_last, out_ready,
        input  in_ready, out_valid, buf_wen, buf_waddr, buf_raddr, count, busy, done
    );
    modport slave (
        input  in_valid, in_last, out_ready,
        output in_ready, out_valid, buf_wen, buf_waddr, buf_raddr, count, busy, done
    );
`endif
endinterface

// File: rtl/buffer_window_ctrl.sv
// Circular-store sequencer for the multi-port column buffer: PAR_WRITE rows in per beat, sliding PAR_READ-row window out.
// Rows written at edge N are readable from cycle N+1; flags and addresses come from registered state only.
// in_ready drops when fewer than PAR_WRITE rows are free or while draining; BUF_WINDOW_CTRL_STATS_EN adds stall counters.
module buffer_window_ctrl #(
    parameter int COLUMNS   = 32,
    parameter int PAR_WRITE = 4,
    parameter int PAR_READ  = 4,
    parameter int STRIDE    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    buffer_window_ctrl_if.slave   bus
);
    localparam int AW = $clog2(COLUMNS);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] COLS_C = CW'(COLUMNS);
    localparam logic [CW-1:0] PW_C   = CW'(PAR_WRITE);
    localparam logic [CW-1:0] PR_C   = CW'(PAR_READ);
    localparam logic [CW-1:0] ST_C   = CW'(STRIDE);
    localparam logic [AW-1:0] PW_INC = AW'(PAR_WRITE);
    localparam logic [AW-1:0] ST_INC = AW'(STRIDE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d, count_upd;
    logic            done_q, done_d;
    logic            rdy, vld, push, pop;

    // Flow-control flags look only at registered count: a pop never frees space in its own cycle.
    assign rdy  = ((COLS_C - count_q) >= PW_C) && (state_q != DRAIN);
    assign vld  = (count_q >= PR_C) && (state_q != IDLE);
    assign push = bus.in_valid && rdy;
    assign pop  = vld && bus.out_ready;

    assign count_upd = count_q + (push ? PW_C : '0) - (pop ? ST_C : '0);

    always_comb begin
        state_d = state_q;
        wptr_d  = push ? wptr_q + PW_INC : wptr_q;
        rptr_d  = pop  ? rptr_q + ST_INC : rptr_q;
        count_d = count_upd;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = bus.in_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (push && bus.in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A partial window can never be presented, so the tail is dropped and the read side resyncs.
                if (count_upd < PR_C) begin
                    state_d = IDLE;
                    rptr_d  = wptr_q;
                    count_d = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Slot offsets wrap naturally in AW bits, so a window may straddle row COLUMNS-1 to row 0.
    for (genvar i = 0; i < PAR_WRITE; i++) begin : g_waddr
        assign bus.buf_waddr[i*AW +: AW] = wptr_q + AW'(i);
    end

    for (genvar j = 0; j < PAR_READ; j++) begin : g_raddr
        assign bus.buf_raddr[j*AW +: AW] = rptr_q + AW'(j);
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.buf_wen   = push;
    assign bus.count     = count_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

`ifdef BUF_WINDOW_CTRL_STATS_EN
    logic [15:0] wr_stall_q;
    logic [15:0] rd_stall_q;

    always_ff @(posedge clk) begin
        if (rst || done_d) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else begin
            if (bus.in_valid && !rdy && (wr_stall_q != 16'hFFFF)) begin
                wr_stall_q <= wr_stall_q + 16'd1;
            end
            if (bus.out_ready && !vld && (state_q != IDLE) && (rd_stall_q != 16'hFFFF)) begin
                rd_stall_q <= rd_stall_q + 16'd1;
            end
        end
    end

    assign bus.wr_stall_cnt = wr_stall_q;
    assign bus.rd_stall_cnt = rd_stall_q;
`endif

endmodule

// File: tb/tb_buffer_window_ctrl.sv
// Bench for buffer_window_ctrl: row-address scoreboard checked every cycle plus directed frame scenarios.
module tb_buffer_window_ctrl;
    localparam int COLUMNS   = 32;
    localparam int PAR_WRITE = 4;
    localparam int PAR_READ  = 4;
    localparam int STRIDE    = 1;
    localparam int AW        = $clog2(COLUMNS);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    buffer_window_ctrl_if #(.COLUMNS(COLUMNS), .PAR_WRITE(PAR_WRITE), .PAR_READ(PAR_READ)) bus ();

    buffer_window_ctrl #(
        .COLUMNS  (COLUMNS),
        .PAR_WRITE(PAR_WRITE),
        .PAR_READ (PAR_READ),
        .STRIDE   (STRIDE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*AW-1:0] win4(input int a, input int b, input int c, input int d);
        return {AW'(d), AW'(c), AW'(b), AW'(a)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: row addresses queued on every push, window checked against the queue head on every pop.
    int q[$];
    int m_wptr  = 0;
    int m_state = 0;
    bit exp_done = 1'b0;

    always @(negedge clk) begin
        bit er, ev, push, pop, nd;
        logic [PAR_WRITE*AW-1:0] ew;
        logic [PAR_READ*AW-1:0]  erd;
        if (rst) begin
            q.delete();
            m_wptr   = 0;
            m_state  = 0;
            exp_done = 1'b0;
        end else begin
            er = ((COLUMNS - q.size()) >= PAR_WRITE) && (m_state != 2);
            ev = (q.size() >= PAR_READ) && (m_state != 0);
            check("sb_in_ready",  32'(bus.in_ready),  32'(er));
            check("sb_out_valid", 32'(bus.out_valid), 32'(ev));
            check("sb_count",     32'(bus.count),     32'(q.size()));
            check("sb_busy",      32'(bus.busy),      32'(m_state != 0));
            check("sb_done",      32'(bus.done),      32'(exp_done));
            check("sb_buf_wen",   32'(bus.buf_wen),   32'(bus.in_valid && er));
            for (int i = 0; i < PAR_WRITE; i++) ew[i*AW +: AW] = AW'((m_wptr + i) % COLUMNS);
            check("sb_buf_waddr", 32'(bus.buf_waddr), 32'(ew));
            if (ev) begin
                for (int j = 0; j < PAR_READ; j++) erd[j*AW +: AW] = AW'(q[j]);
                check("sb_buf_raddr", 32'(bus.buf_raddr), 32'(erd));
            end
            push = bus.in_valid && er;
            pop  = ev && bus.out_ready;
            nd   = 1'b0;
            if (pop) repeat (STRIDE) void'(q.pop_front());
            if (push) begin
                for (int i = 0; i < PAR_WRITE; i++) q.push_back((m_wptr + i) % COLUMNS);
                m_wptr = (m_wptr + PAR_WRITE) % COLUMNS;
            end
            case (m_state)
                0: if (push) m_state = bus.in_last ? 2 : 1;
                1: if (push && bus.in_last) m_state = 2;
                default: if (q.size() < PAR_READ) begin
                    m_state = 0;
                    q.delete();
                    nd = 1'b1;
                end
            endcase
            exp_done = nd;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int n_win, n_done;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;

        // Idle after reset
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("rst_in_ready",  32'(bus.in_ready),  32'd1);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_count",     32'(bus.count),     32'd0);
            check("rst_busy",      32'(bus.busy),      32'd0);
        end

        // Single push then single pop
        bus.in_valid = 1'b1;
        check("t2_waddr", 32'(bus.buf_waddr), 32'(win4(0, 1, 2, 3)));
        cyc();
        bus.in_valid = 1'b0;
        check("t2_count",     32'(bus.count),     32'd4);
        check("t2_out_valid", 32'(bus.out_valid), 32'd1);
        check("t2_raddr",     32'(bus.buf_raddr), 32'(win4(0, 1, 2, 3)));
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        check("t2_raddr_pop", 32'(bus.buf_raddr), 32'(win4(1, 2, 3, 4)));
        check("t2_count_pop", 32'(bus.count),     32'd3);
        check("t2_ov_pop",    32'(bus.out_valid), 32'd0);

        // Fill to full, then free space one row at a time
        do_reset();
        bus.in_valid = 1'b1;
        repeat (8) cyc();
        check("t3_count_full", 32'(bus.count),    32'd32);
        check("t3_ready_full", 32'(bus.in_ready), 32'd0);
        check("t3_wen_full",   32'(bus.buf_wen),  32'd0);
        cyc();
        bus.in_valid = 1'b0;
        check("t3_count_9th", 32'(bus.count), 32'd32);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        check("t3_count_31", 32'(bus.count),    32'd31);
        check("t3_ready_31", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        bus.out_ready = 1'b0;
        check("t3_count_28", 32'(bus.count),    32'd28);
        check("t3_ready_28", 32'(bus.in_ready), 32'd1);

        // Wrap: write side at row 0 again, then walk the read side to straddle the end
        bus.in_valid = 1'b1;
        check("t4_waddr_wrap", 32'(bus.buf_waddr), 32'(win4(0, 1, 2, 3)));
        cyc();
        bus.in_valid = 1'b0;
        check("t4_count", 32'(bus.count), 32'd32);
        bus.out_ready = 1'b1;
        repeat (26) cyc();
        bus.out_ready = 1'b0;
        check("t4_count_6",    32'(bus.count),     32'd6);
        check("t4_raddr_wrap", 32'(bus.buf_raddr), 32'(win4(30, 31, 0, 1)));
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        check("t4_raddr_wrap2", 32'(bus.buf_raddr), 32'(win4(31, 0, 1, 2)));

        // Three-beat frame drained with continuous out_ready
        do_reset();
        n_win  = 0;
        n_done = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            bus.in_valid = (k < 3);
            bus.in_last  = (k == 2);
            #1;
            if (bus.out_valid && bus.out_ready) n_win++;
            cyc();
            if (bus.done) begin
                n_done++;
                check("t5_done_count", 32'(bus.count),             32'd0);
                check("t5_done_rptr",  32'(bus.buf_raddr[AW-1:0]), 32'd12);
                check("t5_done_wptr",  32'(bus.buf_waddr[AW-1:0]), 32'd12);
                check("t5_done_busy",  32'(bus.busy),              32'd0);
            end
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        check("t5_windows",    32'(n_win),  32'd9);
        check("t5_done_pulse", 32'(n_done), 32'd1);

        // Reset while draining
        do_reset();
        bus.in_valid = 1'b1;
        cyc();
        bus.in_last = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("t6_count_8",   32'(bus.count),    32'd8);
        check("t6_busy",      32'(bus.busy),     32'd1);
        check("t6_ready_drn", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        check("t6_count_7", 32'(bus.count), 32'd7);
        do_reset();
        check("t6_rst_count", 32'(bus.count),     32'd0);
        check("t6_rst_busy",  32'(bus.busy),      32'd0);
        check("t6_rst_ov",    32'(bus.out_valid), 32'd0);
        check("t6_rst_done",  32'(bus.done),      32'd0);
`ifdef BUF_WINDOW_CTRL_STATS_EN
        check("t6_rst_wr_stall", 32'(bus.wr_stall_cnt), 32'd0);
        check("t6_rst_rd_stall", 32'(bus.rd_stall_cnt), 32'd0);
`endif
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
